// File: rtl/result_collector_pkg.sv
// Shared types and defaults for the result collector and its buffer.
// Defaults: N=16, Q=8; the index width is derived from Q.
package result_collector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int N_DEF  = 16;
  localparam int Q_DEF  = 8;
  localparam int QW_DEF = clog2(Q_DEF);

endpackage

// File: rtl/result_buffer.sv
// Q x N register file, one write port, registered read port with write-first bypass.
// Read data appears one cycle after rd_en; no backpressure, rd_data holds while idle.
module result_buffer #(
  parameter int N  = 16,
  parameter int Q  = 8,
  parameter int QW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [QW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [QW-1:0] rd_addr,
  input  logic          rd_ok,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          rd_err
);

  logic [N-1:0] r_mem [Q];
  logic [N-1:0] r_rd_data;
  logic         r_rd_valid;
  logic         r_rd_err;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_err   <= rd_en && !rd_ok;
      if (rd_en) begin
        if (!rd_ok)
          r_rd_data <= '0;
        else if (wr_en && (wr_addr == rd_addr))
          r_rd_data <= wr_data;
        else
          r_rd_data <= r_mem[rd_addr];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;

endmodule

// File: rtl/result_collector.sv
// Collects one result per res_write into a Q-entry batch, tracking count and signed max/argmax.
// Status updates the cycle after each strobe; reads are one-cycle registered; no backpressure.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int Q  = Q_DEF,
  parameter int QW = QW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          res_write,
  input  logic [N-1:0]  res_in,
  input  logic          done_in,
  input  logic          rd_en,
  input  logic [QW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          rd_err,
  output logic [QW:0]   count,
  output logic [N-1:0]  max_val,
  output logic [QW-1:0] max_idx,
  output logic          busy,
  output logic          batch_done,
  output logic          short_batch,
  output logic          overflow
);

  localparam logic [QW:0] QCNT = (QW+1)'(Q);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [QW:0]   r_count;
  logic [N-1:0]  r_max_val;
  logic [QW-1:0] r_max_idx;
  logic          r_short;
  logic          r_ovf;

  logic          w_wr;
  logic          w_drop;
  logic          w_new_max;
  logic          w_to_complete;
  logic          w_rd_ok;
  logic [QW:0]   w_cnt_nxt;

  // st takes priority: a strobe in the same cycle is neither stored nor counted as overflow.
  assign w_wr      = (r_state == COLLECT) && res_write && !st && (r_count < QCNT);
  assign w_drop    = res_write && !st &&
                     (((r_state == COLLECT) && (r_count == QCNT)) || (r_state == COMPLETE));
  assign w_cnt_nxt = r_count + {{QW{1'b0}}, w_wr};
  assign w_new_max = w_wr && ((r_count == '0) || ($signed(res_in) > $signed(r_max_val)));
  // Bound includes a same-cycle write so a write-first read of that slot is legal.
  assign w_rd_ok   = ({1'b0, rd_addr} < w_cnt_nxt);

  always_comb begin
    w_state_nxt   = r_state;
    w_to_complete = 1'b0;
    if (st) begin
      w_state_nxt = COLLECT;
    end else if (r_state == COLLECT && (done_in || (w_cnt_nxt == QCNT))) begin
      w_to_complete = 1'b1;
      w_state_nxt   = COMPLETE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
      r_short   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (st) begin
        r_count   <= '0;
        r_max_val <= '0;
        r_max_idx <= '0;
        r_short   <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_wr) r_count <= w_cnt_nxt;
        if (w_new_max) begin
          r_max_val <= res_in;
          r_max_idx <= r_count[QW-1:0];
        end
        if (w_drop) r_ovf <= 1'b1;
        if (w_to_complete && (w_cnt_nxt < QCNT)) r_short <= 1'b1;
      end
    end
  end

  result_buffer #(.N(N), .Q(Q), .QW(QW)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr),
    .wr_addr  (r_count[QW-1:0]),
    .wr_data  (res_in),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_ok    (w_rd_ok),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  assign count       = r_count;
  assign max_val     = r_max_val;
  assign max_idx     = r_max_idx;
  assign busy        = (r_state == COLLECT);
  assign batch_done  = (r_state == COMPLETE);
  assign short_batch = r_short;
  assign overflow    = r_ovf;

endmodule
